counter_sched: RTL and testbench

//  Round-robin scheduler that shares one counter_r0 instance among N_REQ requesters.

---
 rtl/counter_sched.sv | 203 ++++++++++++++++++++
 tb/tb_counter_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one interval counter among N_REQ requesters
// counter_r0 is the shared wrapping counter; counter_sched grants, loads and runs it per request.

module counter_r0 #(
    parameter int MAX_COUNT = 32,
    parameter int BIT_WIDTH = 6,
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 run_i,
    input  logic [BIT_WIDTH-1:0] data_i,
    output logic [BIT_WIDTH-1:0] count_o
);
    logic [BIT_WIDTH-1:0] cnt_q;
    logic [BIT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = data_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == BIT_WIDTH'(MAX_COUNT)) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Optional output retiming stages; DELAY=0 exposes the live count.
    if (DELAY == 0) begin : g_nodly
        assign count_o = cnt_q;
    end else begin : g_dly
        logic [BIT_WIDTH-1:0] pipe_q [DELAY];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= cnt_q;
                for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign count_o = pipe_q[DELAY-1];
    end
endmodule

module counter_sched #(
    parameter int N_REQ     = 4,
    parameter int GNT_W     = 2,
    parameter int MAX_COUNT = 32,
    parameter int BIT_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       abort,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_start,
    input  logic [N_REQ*BIT_WIDTH-1:0] req_stop,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic                       busy,
    output logic [GNT_W-1:0]           grant_id,
    output logic [BIT_WIDTH-1:0]       count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [GNT_W-1:0]     last_grant_q, last_grant_d;
    logic [GNT_W-1:0]     grant_q, grant_d;
    logic [BIT_WIDTH-1:0] start_q, start_d;
    logic [BIT_WIDTH-1:0] stop_q, stop_d;
    logic                 err_q, err_d;

    logic                 cnt_load;
    logic                 cnt_run;
    logic [BIT_WIDTH-1:0] cnt_data;

    logic                 found;
    logic [GNT_W-1:0]     pick;
    logic [BIT_WIDTH-1:0] pick_start;
    logic [BIT_WIDTH-1:0] pick_stop;

    counter_r0 #(
        .MAX_COUNT (MAX_COUNT),
        .BIT_WIDTH (BIT_WIDTH),
        .DELAY     (0)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .run_i   (cnt_run),
        .data_i  (cnt_data),
        .count_o (count)
    );

    // Walk from the highest offset down so the nearest requester after last_grant wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(last_grant_q) + 1 + k) % N_REQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                pick  = GNT_W'(idx);
            end
        end
        pick_start = req_start[pick*BIT_WIDTH +: BIT_WIDTH];
        pick_stop  = req_stop[pick*BIT_WIDTH +: BIT_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        start_d      = start_q;
        stop_d       = stop_q;
        err_d        = err_q;
        req_ready    = '0;
        done         = '0;
        err          = 1'b0;
        cnt_load     = 1'b0;
        cnt_run      = 1'b0;
        cnt_data     = start_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[pick] = 1'b1;
                    grant_d         = pick;
                    start_d         = pick_start;
                    stop_d          = pick_stop;
                    if (pick_start > BIT_WIDTH'(MAX_COUNT) || pick_stop > BIT_WIDTH'(MAX_COUNT)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                if (abort) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_run = tick & (count != stop_q);
                if (abort) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (count == stop_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done[grant_q] = 1'b1;
                err           = err_q;
                err_d         = 1'b0;
                last_grant_d  = grant_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_W'(N_REQ - 1);
            grant_q      <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            err_q        <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
endmodule

// File: tb/tb_counter_sched.sv
// tb/tb_counter_sched.sv - self-checking bench for counter_sched with a job-level reference model
module tb_counter_sched;
    localparam int N    = 4;
    localparam int W    = 6;
    localparam int MAXC = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tick = 1'b0;
    logic           abort = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_start = '0;
    logic [N*W-1:0] req_stop = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   done;
    logic           err;
    logic           busy;
    logic [1:0]     grant_id;
    logic [W-1:0]   count;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int tick_mode = 0;

    counter_sched #(.N_REQ(N), .GNT_W(2), .MAX_COUNT(MAXC), .BIT_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .abort     (abort),
        .req_valid (req_valid),
        .req_start (req_start),
        .req_stop  (req_stop),
        .req_ready (req_ready),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .grant_id  (grant_id),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Cycle counter and gated tick generator (1-in-3 when tick_mode==1).
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (tick_mode == 1) begin
                #1;
                tick = (cyc % 3 == 0);
            end
        end
    end

    // Reference model: one job record with its age, a round-robin pointer and a count value.
    bit m_valid = 0;
    bit j_act, fin, je;
    int jg, js, jp, age, rr, m_grant, m_cnt;

    always @(negedge clk) begin
        int pick;
        int exp_ready;
        int old;
        pick = -1;
        if (!j_act) begin
            for (int k = N - 1; k >= 0; k--) begin
                int idx;
                idx = (rr + 1 + k) % N;
                if (req_valid[idx]) pick = idx;
            end
        end
        if (m_valid) begin
            exp_ready = (pick >= 0) ? (1 << pick) : 0;
            chk("req_ready", req_ready, exp_ready);
            chk("done", done, fin ? (1 << jg) : 0);
            chk("err", err, (fin && je) ? 1 : 0);
            chk("busy", busy, j_act ? 1 : 0);
            chk("grant_id", grant_id, m_grant);
            chk("count", count, m_cnt);
        end
        if (rst) begin
            j_act = 0; fin = 0; je = 0; rr = N - 1; m_grant = 0; m_cnt = 0; age = 0; jg = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (!j_act) begin
                if (pick >= 0) begin
                    j_act = 1; jg = pick; m_grant = pick;
                    js = req_start[pick*W +: W];
                    jp = req_stop[pick*W +: W];
                    je = (js > MAXC) || (jp > MAXC);
                    fin = je;
                    age = 1;
                end
            end else if (fin) begin
                j_act = 0; fin = 0; je = 0; rr = jg;
            end else if (age == 1) begin
                m_cnt = js;
                if (abort) begin j_act = 0; rr = jg; end
                else age = 2;
            end else begin
                old = m_cnt;
                if (tick && old != jp) m_cnt = (old == MAXC) ? 0 : old + 1;
                if (abort) begin j_act = 0; rr = jg; end
                else if (old == jp) fin = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input int s, input int p);
        req_start[idx*W +: W] = W'(s);
        req_stop[idx*W +: W]  = W'(p);
        req_valid[idx] = 1'b1;
    endtask

    task automatic wait_ready(input int idx, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready[idx]) begin t = cyc; break; end
        end
        if (t < 0) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_done(input int idx, output int t, output int e);
        t = -1; e = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done[idx]) begin t = cyc; e = err; break; end
        end
        if (t < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_one(input string name, input int idx, input int s, input int p,
                           input int exp_lat, input int exp_err);
        int ta, td, e;
        set_req(idx, s, p);
        wait_ready(idx, ta);
        step();
        req_valid[idx] = 1'b0;
        wait_done(idx, td, e);
        if (exp_lat >= 0) chk({name, "_latency"}, td - ta, exp_lat);
        chk({name, "_err"}, e, exp_err);
        step();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int ta, td, e, n_rdy;
        int seq [5];
        int dcnt [N];

        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        tick = 1'b1;

        // 1: basic interval, 3..7 -> done 7 cycles after accept
        run_one("t1", 0, 3, 7, 7, 0);

        // 2: wrap 30 -> 2 through MAX_COUNT: 3 + (2-30) mod 33 = 8
        run_one("t2", 1, 30, 2, 8, 0);

        // 3: all requesters valid from reset: grants 0,1,2,3,0
        pulse_rst();
        for (int i = 0; i < N; i++) begin
            set_req(i, 5, 5);
            dcnt[i] = 0;
        end
        n_rdy = 0;
        for (int c = 0; c < 100 && n_rdy < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin seq[n_rdy] = i; n_rdy++; end
                if (done[i]) dcnt[i]++;
            end
            step();
        end
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (done[i]) dcnt[i]++;
            step();
        end
        chk("t3_nready", n_rdy, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_grant%0d", i), seq[i], i % N);
        chk("t3_done0", dcnt[0], 2);
        for (int i = 1; i < N; i++) chk($sformatf("t3_done%0d", i), dcnt[i], 1);

        // 4: tick gated 1-in-3; model tracks the held count
        tick_mode = 1;
        run_one("t4", 2, 0, 2, -1, 0);
        tick_mode = 0;
        #1;
        tick = 1'b1;

        // 5: abort exactly when count==stop; req1 accepted at T, count 6 at T+4
        set_req(1, 4, 6);
        wait_ready(1, ta);
        step();
        req_valid[1] = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;
        set_req(1, 1, 1);
        set_req(2, 1, 1);
        @(negedge clk);
        chk("t5_count_at_abort", count, 6);
        chk("t5_no_done_abort", done, 0);
        step();
        abort = 1'b0;
        wait_ready(2, td);
        chk("t5_next_grant_cycle", td - ta, 5);
        chk("t5_no_done_after", done, 0);
        step();
        req_valid = '0;
        wait_done(2, td, e);
        chk("t5_err", e, 0);
        step();

        // 6: out-of-range stop -> done+err one cycle after accept
        run_one("t6", 3, 0, 40, 1, 1);
        set_req(0, 0, 20);
        wait_ready(0, ta);
        step();
        req_valid = '0;
        repeat (5) step();
        @(negedge clk);
        chk("t6_busy_pre_rst", busy, 1);
        step();
        pulse_rst();
        @(negedge clk);
        chk("t6_busy_post_rst", busy, 0);
        chk("t6_count_post_rst", count, 0);
        chk("t6_done_post_rst", done, 0);
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
